// File: rtl/hop_sel_if.sv
// Slot-level handshake and control-word bundle between the hop control word
// generator (master) and the hop selection kernel (slave).
interface hop_sel_if;
    logic        hop_start_p;
    logic        afh_en;
    logic [4:0]  x;
    logic        y1;
    logic [5:0]  y2;
    logic [4:0]  a;
    logic [3:0]  b;
    logic [4:0]  c;
    logic [8:0]  d;
    logic [6:0]  e;
    logic [6:0]  f;
    logic [6:0]  fprime;
    logic [6:0]  regi_afh_n;
    logic [78:0] regi_chan_map;
    logic        busy;
    logic        hop_valid_p;
    logic [6:0]  hop_chan;
    logic        afh_remap;
    logic        afh_err;

    modport master (
        output hop_start_p, afh_en, x, y1, y2, a, b, c, d, e, f, fprime,
               regi_afh_n, regi_chan_map,
        input  busy, hop_valid_p, hop_chan, afh_remap, afh_err
    );

    modport slave (
        input  hop_start_p, afh_en, x, y1, y2, a, b, c, d, e, f, fprime,
               regi_afh_n, regi_chan_map,
        output busy, hop_valid_p, hop_chan, afh_remap, afh_err
    );
endinterface

// File: rtl/hop_sel_kernel.sv
// Hop selection kernel: ADD/XOR/PERM5/ADD mod 79 basic channel selection with
// optional adaptive remap of unused channels onto the used-channel list.
module hop_sel_kernel #(
    parameter int unsigned AFH_N_MIN = 20
) (
    input  logic     clk_6M,
    input  logic     rstz,
    hop_sel_if.slave bus
);

    localparam logic [6:0] LP_N_MIN   = 7'(AFH_N_MIN);
    localparam logic [6:0] LP_LAST_J  = 7'd78;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_MAP    = 3'd2,
        S_AFHMOD = 3'd3,
        S_SCAN   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [4:0] swap_bits(input logic [4:0] v, input logic [2:0] i,
                                             input logic [2:0] j, input logic en);
        logic [4:0] r;
        r = v;
        if (en) begin
            r[i] = v[j];
            r[j] = v[i];
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Butterfly stages applied from P13 down to P0.
    function automatic logic [4:0] perm5(input logic [4:0] z, input logic [13:0] p);
        logic [4:0] v;
        v = z;
        v = swap_bits(v, 3'd1, 3'd2, p[13]);
        v = swap_bits(v, 3'd0, 3'd3, p[12]);
        v = swap_bits(v, 3'd1, 3'd3, p[11]);
        v = swap_bits(v, 3'd2, 3'd4, p[10]);
        v = swap_bits(v, 3'd0, 3'd3, p[9]);
        v = swap_bits(v, 3'd1, 3'd4, p[8]);
        v = swap_bits(v, 3'd3, 3'd4, p[7]);
        v = swap_bits(v, 3'd0, 3'd2, p[6]);
        v = swap_bits(v, 3'd1, 3'd3, p[5]);
        v = swap_bits(v, 3'd0, 3'd4, p[4]);
        v = swap_bits(v, 3'd3, 3'd4, p[3]);
        v = swap_bits(v, 3'd1, 3'd2, p[2]);
        v = swap_bits(v, 3'd2, 3'd3, p[1]);
        v = swap_bits(v, 3'd0, 3'd1, p[0]);
        return v;
    endfunction

    function automatic logic [6:0] mod79(input logic [8:0] s);
        logic [8:0] r;
        if (s >= 9'd237) begin
            r = s - 9'd237;
        end else if (s >= 9'd158) begin
            r = s - 9'd158;
        end else if (s >= 9'd79) begin
            r = s - 9'd79;
        end else begin
            r = s;
        end
        return 7'(r);
    endfunction

    // Register-bank order: evens 0..78 first, then odds 1..77.
    function automatic logic [6:0] bank_chan(input logic [6:0] k);
        logic [5:0] h;
        logic [6:0] t;
        if (k < 7'd40) begin
            t = {k[5:0], 1'b0};
        end else begin
            h = 6'(k - 7'd40);
            t = {h, 1'b1};
        end
        return t;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_x;
    logic        r_y1;
    logic [5:0]  r_y2;
    logic [4:0]  r_a;
    logic [3:0]  r_b;
    logic [4:0]  r_c;
    logic [8:0]  r_d;
    logic [6:0]  r_e;
    logic [6:0]  r_f;
    logic [6:0]  r_fp;
    logic        r_afh_en;
    logic [6:0]  r_afh_n;

    logic [8:0]  r_s;
    logic [8:0]  r_sn;
    logic [6:0]  r_fk;
    logic [6:0]  r_j;
    logic [6:0]  r_cnt;

    logic        r_busy;
    logic        r_hop_valid_p;
    logic [6:0]  r_hop_chan;
    logic        r_afh_remap;
    logic        r_afh_err;

    logic [4:0]  w_z_sum;
    logic [4:0]  w_z;
    logic [13:0] w_p;
    logic [4:0]  w_perm;
    logic [6:0]  w_fk;
    logic        w_fk_used;
    logic [6:0]  w_scan_ch;
    logic        w_scan_used;
    logic        w_sn_ge_n;
    logic        w_go_done;
    logic [6:0]  w_done_chan;
    logic        w_done_remap;
    logic        w_done_err;

    assign w_z_sum     = r_x + r_a;
    assign w_z         = {w_z_sum[4], w_z_sum[3:0] ^ r_b};
    assign w_p         = {r_d, r_c ^ {5{r_y1}}};
    assign w_perm      = perm5(w_z, w_p);
    assign w_fk        = bank_chan(mod79(r_s));
    assign w_fk_used   = bus.regi_chan_map[w_fk];
    assign w_scan_ch   = bank_chan(r_j);
    assign w_scan_used = bus.regi_chan_map[w_scan_ch];
    assign w_sn_ge_n   = (r_sn >= {2'b00, r_afh_n});

    // Next-state selection and the result to publish on entry to DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_done_chan  = r_fk;
        w_done_remap = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.hop_start_p) begin
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                w_state_nxt = S_MAP;
            end
            S_MAP: begin
                w_done_chan = w_fk;
                if (!r_afh_en || w_fk_used) begin
                    w_state_nxt = S_DONE;
                end else if (r_afh_n < LP_N_MIN) begin
                    w_state_nxt = S_DONE;
                    w_done_err  = 1'b1;
                end else begin
                    w_state_nxt = S_AFHMOD;
                end
            end
            S_AFHMOD: begin
                if (w_sn_ge_n) begin
                    w_state_nxt = S_AFHMOD;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_scan_used && ({2'b00, r_cnt} == r_sn)) begin
                    w_state_nxt  = S_DONE;
                    w_done_chan  = w_scan_ch;
                    w_done_remap = 1'b1;
                end else if (r_j == LP_LAST_J) begin
                    w_state_nxt = S_DONE;
                    w_done_err  = 1'b1;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_go_done = (w_state_nxt == S_DONE);

    // State register.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input capture and per-state datapath registers.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_x      <= 5'd0;
            r_y1     <= 1'b0;
            r_y2     <= 6'd0;
            r_a      <= 5'd0;
            r_b      <= 4'd0;
            r_c      <= 5'd0;
            r_d      <= 9'd0;
            r_e      <= 7'd0;
            r_f      <= 7'd0;
            r_fp     <= 7'd0;
            r_afh_en <= 1'b0;
            r_afh_n  <= 7'd0;
            r_s      <= 9'd0;
            r_sn     <= 9'd0;
            r_fk     <= 7'd0;
            r_j      <= 7'd0;
            r_cnt    <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.hop_start_p) begin
                        r_x      <= bus.x;
                        r_y1     <= bus.y1;
                        r_y2     <= bus.y2;
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_c      <= bus.c;
                        r_d      <= bus.d;
                        r_e      <= bus.e;
                        r_f      <= bus.f;
                        r_fp     <= bus.fprime;
                        r_afh_en <= bus.afh_en;
                        r_afh_n  <= bus.regi_afh_n;
                    end
                end
                S_CALC: begin
                    r_s  <= {4'd0, w_perm} + {2'd0, r_e} + {2'd0, r_f}  + {3'd0, r_y2};
                    r_sn <= {4'd0, w_perm} + {2'd0, r_e} + {2'd0, r_fp} + {3'd0, r_y2};
                end
                S_MAP: begin
                    r_fk  <= w_fk;
                    r_j   <= 7'd0;
                    r_cnt <= 7'd0;
                end
                S_AFHMOD: begin
                    if (w_sn_ge_n) begin
                        r_sn <= r_sn - {2'b00, r_afh_n};
                    end
                end
                S_SCAN: begin
                    r_j <= r_j + 7'd1;
                    if (w_scan_used) begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                default: begin
                    r_j <= r_j;
                end
            endcase
        end
    end

    // Registered outputs; results load on the edge that enters DONE.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_busy        <= 1'b0;
            r_hop_valid_p <= 1'b0;
            r_hop_chan    <= 7'd0;
            r_afh_remap   <= 1'b0;
            r_afh_err     <= 1'b0;
        end else begin
            r_busy        <= (w_state_nxt != S_IDLE);
            r_hop_valid_p <= w_go_done;
            if (w_go_done) begin
                r_hop_chan  <= w_done_chan;
                r_afh_remap <= w_done_remap;
                r_afh_err   <= w_done_err;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.hop_valid_p = r_hop_valid_p;
    assign bus.hop_chan    = r_hop_chan;
    assign bus.afh_remap   = r_afh_remap;
    assign bus.afh_err     = r_afh_err;

endmodule

// File: tb/tb_hop_sel_kernel.sv
// Directed bench for hop_sel_kernel: basic selection, PERM5 ordering, mod-79
// boundaries, AFH remap/error paths, busy handling and asynchronous abort.
module tb_hop_sel_kernel;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    hop_sel_if bus();

    hop_sel_kernel #(.AFH_N_MIN(20)) dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus)
    );

    always #83 clk_6M = ~clk_6M;

    task automatic clear_inputs();
        bus.hop_start_p   = 1'b0;
        bus.afh_en        = 1'b0;
        bus.x             = 5'd0;
        bus.y1            = 1'b0;
        bus.y2            = 6'd0;
        bus.a             = 5'd0;
        bus.b             = 4'd0;
        bus.c             = 5'd0;
        bus.d             = 9'd0;
        bus.e             = 7'd0;
        bus.f             = 7'd0;
        bus.fprime        = 7'd0;
        bus.regi_afh_n    = 7'd0;
        bus.regi_chan_map = '0;
    endtask

    // Pulse start, then count cycles until hop_valid_p (bounded at 120).
    task automatic fire(output int lat);
        @(negedge clk_6M);
        bus.hop_start_p = 1'b1;
        @(negedge clk_6M);
        bus.hop_start_p = 1'b0;
        lat = 1;
        while (bus.hop_valid_p !== 1'b1 && lat < 120) begin
            @(negedge clk_6M);
            lat++;
        end
    endtask

    task automatic test_reset();
        rstz = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk_6M);
        n_tests++;
        if ({bus.busy, bus.hop_valid_p, bus.hop_chan, bus.afh_remap, bus.afh_err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h expected 0",
                     {bus.busy, bus.hop_valid_p, bus.hop_chan, bus.afh_remap, bus.afh_err});
        end
        rstz = 1'b1;
        repeat (2) @(negedge clk_6M);
        n_tests++;
        if ({bus.busy, bus.hop_valid_p, bus.hop_chan, bus.afh_remap, bus.afh_err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h expected 0",
                     {bus.busy, bus.hop_valid_p, bus.hop_chan, bus.afh_remap, bus.afh_err});
        end
    endtask

    task automatic test_basic();
        int lat;
        clear_inputs();
        fire(lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 3", lat);
        end
        n_tests++;
        if ({bus.hop_chan, bus.afh_remap, bus.afh_err, bus.busy} !== {7'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_result: chan=%0d remap=%b err=%b busy=%b expected 0/0/0/1",
                     bus.hop_chan, bus.afh_remap, bus.afh_err, bus.busy);
        end
        @(negedge clk_6M);
        n_tests++;
        if ({bus.hop_valid_p, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_pulse_end: valid=%b busy=%b expected 0 0", bus.hop_valid_p, bus.busy);
        end
    endtask

    task automatic test_add_mod();
        logic [4:0] xs [7];
        logic [5:0] y2s[7];
        logic [6:0] es [7];
        logic [6:0] fs [7];
        logic [6:0] exp[7];
        int lat;
        xs  = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        y2s = '{6'd32, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        es  = '{7'd127, 7'd40, 7'd78, 7'd79, 7'd127, 7'd127, 7'd127};
        fs  = '{7'd78, 7'd0, 7'd0, 7'd0, 7'd110, 7'd60, 7'd30};
        // s = 268, 40, 78, 79, 237, 187, 157
        exp = '{7'd62, 7'd1, 7'd77, 7'd0, 7'd0, 7'd58, 7'd77};
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            bus.x  = xs[i];
            bus.y2 = y2s[i];
            bus.e  = es[i];
            bus.f  = fs[i];
            fire(lat);
            n_tests++;
            if (lat !== 3 || bus.hop_chan !== exp[i] || bus.afh_remap !== 1'b0 || bus.afh_err !== 1'b0) begin
                n_fail++;
                $display("FAIL add_mod[%0d]: chan=%0d lat=%0d remap=%b err=%b expected chan=%0d lat=3 flags 0",
                         i, bus.hop_chan, lat, bus.afh_remap, bus.afh_err, exp[i]);
            end
        end
    endtask

    task automatic test_perm();
        logic [4:0] xs [9];
        logic       y1s[9];
        logic [5:0] y2s[9];
        logic [4:0] as_[9];
        logic [3:0] bs [9];
        logic [4:0] cs [9];
        logic [8:0] ds [9];
        logic [6:0] exp[9];
        int lat;
        xs  = '{5'd1, 5'd0, 5'd2, 5'd1, 5'd0, 5'd30, 5'd1, 5'd1, 5'd2};
        y1s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        y2s = '{6'd0, 6'd32, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        as_ = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0};
        bs  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        cs  = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'b11110, 5'd0};
        ds  = '{9'h000, 9'h000, 9'h100, 9'h000, 9'h000, 9'h000, 9'h002, 9'h000, 9'h140};
        // perm = 1, 0, 4, 2, 3, 3, 4, 2, 4 (last: P13 before P11 gives 4, reversed would give 8)
        exp = '{7'd2, 7'd64, 7'd8, 7'd4, 7'd6, 7'd6, 7'd8, 7'd4, 7'd8};
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            bus.x  = xs[i];
            bus.y1 = y1s[i];
            bus.y2 = y2s[i];
            bus.a  = as_[i];
            bus.b  = bs[i];
            bus.c  = cs[i];
            bus.d  = ds[i];
            fire(lat);
            n_tests++;
            if (lat !== 3 || bus.hop_chan !== exp[i]) begin
                n_fail++;
                $display("FAIL perm[%0d]: chan=%0d lat=%0d expected chan=%0d lat=3",
                         i, bus.hop_chan, lat, exp[i]);
            end
        end
    endtask

    task automatic test_afh();
        logic [78:0] map_no2;
        logic [78:0] map_only0;
        int lat;
        map_no2      = '1;
        map_no2[2]   = 1'b0;
        map_only0    = '0;
        map_only0[0] = 1'b1;

        // f_k = 6 is used: no remap, plain latency
        clear_inputs();
        bus.afh_en = 1'b1; bus.regi_chan_map = map_no2; bus.regi_afh_n = 7'd78; bus.x = 5'd3;
        fire(lat);
        n_tests++;
        if (lat !== 3 || bus.hop_chan !== 7'd6 || bus.afh_remap !== 1'b0 || bus.afh_err !== 1'b0) begin
            n_fail++;
            $display("FAIL afh_used: chan=%0d lat=%0d remap=%b err=%b expected 6/3/0/0",
                     bus.hop_chan, lat, bus.afh_remap, bus.afh_err);
        end

        // f_k = 2 unused, k' = 1 -> second used channel = 4
        clear_inputs();
        bus.afh_en = 1'b1; bus.regi_chan_map = map_no2; bus.regi_afh_n = 7'd78; bus.x = 5'd1;
        fire(lat);
        n_tests++;
        if (lat >= 100 || bus.hop_chan !== 7'd4 || bus.afh_remap !== 1'b1 || bus.afh_err !== 1'b0) begin
            n_fail++;
            $display("FAIL afh_remap_n78: chan=%0d lat=%0d remap=%b err=%b expected 4/<100/1/0",
                     bus.hop_chan, lat, bus.afh_remap, bus.afh_err);
        end

        // N = 20 (minimum), sN = 78 -> k' = 18 -> channel 38
        clear_inputs();
        bus.afh_en = 1'b1; bus.regi_chan_map = map_no2; bus.regi_afh_n = 7'd20; bus.x = 5'd1;
        bus.fprime = 7'd77;
        fire(lat);
        n_tests++;
        if (lat >= 100 || bus.hop_chan !== 7'd38 || bus.afh_remap !== 1'b1 || bus.afh_err !== 1'b0) begin
            n_fail++;
            $display("FAIL afh_remap_n20: chan=%0d lat=%0d remap=%b err=%b expected 38/<100/1/0",
                     bus.hop_chan, lat, bus.afh_remap, bus.afh_err);
        end

        // N = 19 below minimum: keep f_k, flag error, no AFH cycles
        bus.regi_afh_n = 7'd19;
        fire(lat);
        n_tests++;
        if (lat !== 3 || bus.hop_chan !== 7'd2 || bus.afh_remap !== 1'b0 || bus.afh_err !== 1'b1) begin
            n_fail++;
            $display("FAIL afh_n19: chan=%0d lat=%0d remap=%b err=%b expected 2/3/0/1",
                     bus.hop_chan, lat, bus.afh_remap, bus.afh_err);
        end

        // Only channel 0 used, k' = 11: scan runs out -> error, f_k kept
        clear_inputs();
        bus.afh_en = 1'b1; bus.regi_chan_map = map_only0; bus.regi_afh_n = 7'd20; bus.x = 5'd1;
        bus.fprime = 7'd10;
        fire(lat);
        n_tests++;
        if (lat >= 100 || bus.hop_chan !== 7'd2 || bus.afh_remap !== 1'b0 || bus.afh_err !== 1'b1) begin
            n_fail++;
            $display("FAIL afh_nomatch: chan=%0d lat=%0d remap=%b err=%b expected 2/<100/0/1",
                     bus.hop_chan, lat, bus.afh_remap, bus.afh_err);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        clear_inputs();
        bus.x = 5'd1;
        fire(lat);
        n_tests++;
        if (lat !== 3 || bus.hop_chan !== 7'd2) begin
            n_fail++;
            $display("FAIL b2b_first: chan=%0d lat=%0d expected 2/3", bus.hop_chan, lat);
        end
        bus.x = 5'd2;
        bus.d = 9'h140;
        fire(lat);
        n_tests++;
        if (lat !== 3 || bus.hop_chan !== 7'd8) begin
            n_fail++;
            $display("FAIL b2b_second: chan=%0d lat=%0d expected 8/3", bus.hop_chan, lat);
        end
    endtask

    task automatic test_start_ignored();
        logic [78:0] map_no2;
        int lat;
        int extra;
        map_no2    = '1;
        map_no2[2] = 1'b0;
        clear_inputs();
        bus.afh_en = 1'b1; bus.regi_chan_map = map_no2; bus.regi_afh_n = 7'd20; bus.x = 5'd1;
        bus.fprime = 7'd77;
        @(negedge clk_6M);
        bus.hop_start_p = 1'b1;
        @(negedge clk_6M);
        bus.hop_start_p = 1'b0;
        repeat (3) @(negedge clk_6M);
        bus.x = 5'd0; bus.afh_en = 1'b0; bus.hop_start_p = 1'b1;
        @(negedge clk_6M);
        bus.hop_start_p = 1'b0;
        lat = 0;
        while (bus.hop_valid_p !== 1'b1 && lat < 120) begin
            @(negedge clk_6M);
            lat++;
        end
        n_tests++;
        if (lat >= 120 || bus.hop_chan !== 7'd38 || bus.afh_remap !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: chan=%0d remap=%b timeout=%b expected 38/1/0",
                     bus.hop_chan, bus.afh_remap, lat >= 120);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_6M);
            if (bus.hop_valid_p === 1'b1) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_no_queue: extra valid pulses=%0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [78:0] map_no2;
        int seen;
        map_no2    = '1;
        map_no2[2] = 1'b0;
        clear_inputs();
        bus.afh_en = 1'b1; bus.regi_chan_map = map_no2; bus.regi_afh_n = 7'd20; bus.x = 5'd1;
        bus.fprime = 7'd77;
        @(negedge clk_6M);
        bus.hop_start_p = 1'b1;
        @(negedge clk_6M);
        bus.hop_start_p = 1'b0;
        repeat (9) @(negedge clk_6M);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.hop_valid_p !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_scan_busy: busy=%b valid=%b expected 1 0", bus.busy, bus.hop_valid_p);
        end
        rstz = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.hop_valid_p, bus.hop_chan, bus.afh_remap, bus.afh_err} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: outputs=%h expected 0",
                     {bus.busy, bus.hop_valid_p, bus.hop_chan, bus.afh_remap, bus.afh_err});
        end
        @(negedge clk_6M);
        rstz = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_6M);
            if (bus.hop_valid_p === 1'b1 || bus.busy === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: cycles with valid/busy after reset=%0d expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_add_mod();
        test_perm();
        test_afh();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
